// File: rtl/ex_stage_if.sv
// EX stage bus bundle: stall vector and ID/EX payload in; MEM, forwarding, control and data SRAM signals out.
interface ex_stage_if #(
  parameter int unsigned ID_TO_EX_WD  = 159,
  parameter int unsigned EX_TO_MEM_WD = 76,
  parameter int unsigned EX_TO_ID_WD  = 38,
  parameter int unsigned STALL_W      = 6
);
  logic [STALL_W-1:0]      stall;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
  logic                    ex_is_load;
  logic                    stallreq_for_ex;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_id_bus, ex_is_load, stallreq_for_ex,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id_bus, ex_is_load, stallreq_for_ex,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, one-hot ALU, data SRAM request, HI/LO and radix-2 restoring divider.
// Optional macro EX_MULT_EN: decode mult/multu and write the 64-bit product into {HI, LO}.
module ex_stage (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);
  localparam int unsigned ID_TO_EX_WD = 159;
  localparam int unsigned DIV_STEPS   = 32;
  localparam int unsigned CNT_W       = 5;

  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;
  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
`ifdef EX_MULT_EN
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

  logic [ID_TO_EX_WD-1:0] r_id_ex;

  // ID/EX register: bubble when EX stops but MEM keeps going
  always_ff @(posedge clk) begin
    if (rst)                                r_id_ex <= '0;
    else if (bus.stall[2] && !bus.stall[3]) r_id_ex <= '0;
    else if (!bus.stall[2])                 r_id_ex <= bus.id_to_ex_bus;
  end

  logic [31:0] w_pc, w_inst, w_rdata1, w_rdata2;
  logic [11:0] w_alu_op;
  logic [2:0]  w_sel_src1;
  logic [3:0]  w_sel_src2, w_ram_wen;
  logic        w_ram_en, w_rf_we_in, w_sel_rf_res;
  logic [4:0]  w_rf_waddr_in;

  assign {w_pc, w_inst, w_alu_op, w_sel_src1, w_sel_src2, w_ram_en, w_ram_wen,
          w_rf_we_in, w_rf_waddr_in, w_sel_rf_res, w_rdata1, w_rdata2} = r_id_ex;

  logic w_special, w_is_div, w_is_divu, w_is_divx, w_is_mfhi, w_is_mflo;
  assign w_special = (w_inst[31:26] == 6'd0);
  assign w_is_div  = w_special && (w_inst[5:0] == FUNC_DIV);
  assign w_is_divu = w_special && (w_inst[5:0] == FUNC_DIVU);
  assign w_is_mfhi = w_special && (w_inst[5:0] == FUNC_MFHI);
  assign w_is_mflo = w_special && (w_inst[5:0] == FUNC_MFLO);
  assign w_is_divx = w_is_div | w_is_divu;

  logic [31:0] w_src1, w_src2;
  assign w_src1 = ({32{w_sel_src1[0]}} & w_rdata1)
                | ({32{w_sel_src1[1]}} & w_pc)
                | ({32{w_sel_src1[2]}} & {27'd0, w_inst[10:6]});
  assign w_src2 = ({32{w_sel_src2[0]}} & w_rdata2)
                | ({32{w_sel_src2[1]}} & {{16{w_inst[15]}}, w_inst[15:0]})
                | ({32{w_sel_src2[2]}} & 32'd8)
                | ({32{w_sel_src2[3]}} & {16'd0, w_inst[15:0]});

  logic [31:0] w_add, w_sub, w_slt, w_sltu, w_sll, w_srl, w_sra, w_lui, w_alu_res;
  assign w_add  = w_src1 + w_src2;
  assign w_sub  = w_src1 - w_src2;
  assign w_slt  = {31'd0, $signed(w_src1) < $signed(w_src2)};
  assign w_sltu = {31'd0, w_src1 < w_src2};
  assign w_sll  = w_src2 << w_src1[4:0];
  assign w_srl  = w_src2 >> w_src1[4:0];
  assign w_sra  = 32'($signed(w_src2) >>> w_src1[4:0]);
  assign w_lui  = {w_src2[15:0], 16'd0};

  assign w_alu_res = ({32{w_alu_op[11]}} & w_add)
                   | ({32{w_alu_op[10]}} & w_sub)
                   | ({32{w_alu_op[9]}}  & w_slt)
                   | ({32{w_alu_op[8]}}  & w_sltu)
                   | ({32{w_alu_op[7]}}  & (w_src1 & w_src2))
                   | ({32{w_alu_op[6]}}  & ~(w_src1 | w_src2))
                   | ({32{w_alu_op[5]}}  & (w_src1 | w_src2))
                   | ({32{w_alu_op[4]}}  & (w_src1 ^ w_src2))
                   | ({32{w_alu_op[3]}}  & w_sll)
                   | ({32{w_alu_op[2]}}  & w_srl)
                   | ({32{w_alu_op[1]}}  & w_sra)
                   | ({32{w_alu_op[0]}}  & w_lui);

  logic [31:0] r_hi, r_lo;
  logic [31:0] w_ex_result;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;

  // mfhi/mflo write rd regardless of what ID decoded for rf_we/rf_waddr
  always_comb begin
    w_ex_result = w_alu_res;
    w_rf_we     = w_rf_we_in;
    w_rf_waddr  = w_rf_waddr_in;
    if (w_is_mfhi || w_is_mflo) begin
      w_ex_result = w_is_mfhi ? r_hi : r_lo;
      w_rf_we     = 1'b1;
      w_rf_waddr  = w_inst[15:11];
    end
  end

  div_state_e         r_state, w_next;
  logic               w_stallreq;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_quo, r_rem, r_dvs;
  logic               r_q_neg, r_r_neg;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_stallreq = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_divx) begin
          w_stallreq = 1'b1;
          w_next     = (w_rdata2 == 32'd0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        w_stallreq = 1'b1;
        if (r_cnt == CNT_W'(DIV_STEPS - 1)) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  logic [31:0] w_dvd_abs, w_dvs_abs, w_rem_sub, w_lo_fix, w_hi_fix;
  logic [32:0] w_rem_sh;
  logic        w_rem_ge;
  assign w_dvd_abs = (w_is_div && w_rdata1[31]) ? (~w_rdata1 + 32'd1) : w_rdata1;
  assign w_dvs_abs = (w_is_div && w_rdata2[31]) ? (~w_rdata2 + 32'd1) : w_rdata2;
  assign w_rem_sh  = {r_rem, r_quo[31]};
  assign w_rem_ge  = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_sub = 32'(w_rem_sh - {1'b0, r_dvs});
  assign w_lo_fix  = r_q_neg ? (~r_quo + 32'd1) : r_quo;
  assign w_hi_fix  = r_r_neg ? (~r_rem + 32'd1) : r_rem;

  // Divider datapath; a zero divisor preloads the final results with no sign fix-up
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_divx) begin
            r_cnt <= '0;
            if (w_rdata2 == 32'd0) begin
              r_quo   <= '1;
              r_rem   <= w_rdata1;
              r_q_neg <= 1'b0;
              r_r_neg <= 1'b0;
            end else begin
              r_quo   <= w_dvd_abs;
              r_rem   <= '0;
              r_dvs   <= w_dvs_abs;
              r_q_neg <= w_is_div & (w_rdata1[31] ^ w_rdata2[31]);
              r_r_neg <= w_is_div & w_rdata1[31];
            end
          end
        end
        S_BUSY: begin
          r_quo <= {r_quo[30:0], w_rem_ge};
          r_rem <= w_rem_ge ? w_rem_sub : w_rem_sh[31:0];
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef EX_MULT_EN
  logic        w_is_mult, w_is_multu, w_mult_we;
  logic [63:0] w_prod;
  assign w_is_mult  = w_special && (w_inst[5:0] == FUNC_MULT);
  assign w_is_multu = w_special && (w_inst[5:0] == FUNC_MULTU);
  assign w_prod     = w_is_mult
                    ? 64'($signed({{32{w_rdata1[31]}}, w_rdata1}) * $signed({{32{w_rdata2[31]}}, w_rdata2}))
                    : ({32'd0, w_rdata1} * {32'd0, w_rdata2});
  assign w_mult_we  = (w_is_mult | w_is_multu) & ~bus.stall[2];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_DONE) begin
      r_hi <= w_hi_fix;
      r_lo <= w_lo_fix;
    end
`ifdef EX_MULT_EN
    else if (w_mult_we) begin
      {r_hi, r_lo} <= w_prod;
    end
`endif
  end

  logic w_unused_bits;
  assign w_unused_bits = ^{w_inst[25:16], bus.stall[5:4], bus.stall[1:0]};

  assign bus.ex_to_mem_bus   = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res, w_rf_we, w_rf_waddr, w_ex_result};
  assign bus.ex_to_id_bus    = {w_rf_we & ~w_sel_rf_res, w_rf_waddr, w_ex_result};
  assign bus.ex_is_load      = w_ram_en & w_sel_rf_res & (w_ram_wen == 4'd0);
  assign bus.stallreq_for_ex = w_stallreq;
  assign bus.data_sram_en    = w_ram_en;
  assign bus.data_sram_wen   = w_ram_wen;
  assign bus.data_sram_addr  = w_alu_res;
  assign bus.data_sram_wdata = w_rdata2;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed and random ALU, memory path, stall, divider, reset and mult handling.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst;
  logic r_auto;
  logic [5:0] r_stall;
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  ex_stage_if bus ();
  ex_stage u_dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Control-unit stand-in: a busy divider freezes IF..EX
  assign bus.stall = r_auto ? (bus.stallreq_for_ex ? 6'b001111 : 6'b000000) : r_stall;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
      input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2, input logic en,
      input logic [3:0] wen, input logic we, input logic [4:0] wa, input logic sres,
      input logic [31:0] d1, input logic [31:0] d2);
    return {pc, inst, op, s1, s2, en, wen, we, wa, sres, d1, d2};
  endfunction

  function automatic logic [158:0] mk_mf(input logic hi, input logic [4:0] rd);
    logic [31:0] inst;
    inst = {16'd0, rd, 5'd0, hi ? 6'h10 : 6'h12};
    return mk(32'h400, inst, 12'h0, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
  endfunction

  // Operation index k: 0 add,1 sub,2 slt,3 sltu,4 and,5 nor,6 or,7 xor,8 sll,9 srl,10 sra,11 lui
  function automatic logic [31:0] ref_alu(input int k, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (k)
      0:  return a + b;
      1:  return a - b;
      2:  return (sa < sb) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return b << a[4:0];
      9:  return b >> a[4:0];
      10: return sb >>> a[4:0];
      11: return {b[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint la, lb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      la = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      lb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      lq = la / lb;
      lr = la % lb;
      q = lq[31:0];
      r = lr[31:0];
    end
  endtask

  task automatic issue(input logic [158:0] b);
    @(negedge clk);
    bus.id_to_ex_bus = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    r_auto = 1'b0;
    r_stall = 6'd0;
    bus.id_to_ex_bus = mk(32'h100, 32'h2008_0005, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b1, 5'd8, 1'b0, 32'd3, 32'd4);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.ex_to_mem_bus !== 76'd0) begin n_fail++; $display("FAIL reset_mem_bus: got %h expected 0", bus.ex_to_mem_bus); end
    n_checks++; if (bus.ex_to_id_bus !== 38'd0) begin n_fail++; $display("FAIL reset_id_bus: got %h expected 0", bus.ex_to_id_bus); end
    n_checks++; if (bus.stallreq_for_ex !== 1'b0 || bus.data_sram_en !== 1'b0 || bus.ex_is_load !== 1'b0 || bus.data_sram_wen !== 4'd0)
      begin n_fail++; $display("FAIL reset_ctrl: got stallreq=%b en=%b load=%b wen=%h expected all 0", bus.stallreq_for_ex, bus.data_sram_en, bus.ex_is_load, bus.data_sram_wen); end
    @(negedge clk);
    rst = 1'b0;
    issue(mk_mf(1'b1, 5'd3));
    n_checks++; if (bus.ex_to_id_bus !== {1'b1, 5'd3, 32'd0}) begin n_fail++; $display("FAIL reset_hi: got %h expected %h", bus.ex_to_id_bus, {1'b1, 5'd3, 32'd0}); end
    issue(mk_mf(1'b0, 5'd4));
    n_checks++; if (bus.ex_to_id_bus !== {1'b1, 5'd4, 32'd0}) begin n_fail++; $display("FAIL reset_lo: got %h expected %h", bus.ex_to_id_bus, {1'b1, 5'd4, 32'd0}); end
  endtask

  task automatic test_alu_directed();
    r_auto = 1'b0;
    r_stall = 6'd0;
    issue(mk(32'h100, {6'h09, 5'd0, 5'd5, 16'h0001}, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h7FFF_FFFF, 32'd0));
    n_checks++; if (bus.ex_to_id_bus !== {1'b1, 5'd5, 32'h8000_0000}) begin n_fail++; $display("FAIL addiu_fwd: got %h expected %h", bus.ex_to_id_bus, {1'b1, 5'd5, 32'h8000_0000}); end
    n_checks++; if (bus.ex_to_mem_bus !== {32'h100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h8000_0000}) begin n_fail++; $display("FAIL addiu_mem: got %h expected %h", bus.ex_to_mem_bus, {32'h100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h8000_0000}); end
    issue(mk(32'h104, {6'h0F, 5'd0, 5'd6, 16'h1234}, 12'h001, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd6, 1'b0, 32'd0, 32'd0));
    n_checks++; if (bus.ex_to_mem_bus[31:0] !== 32'h1234_0000) begin n_fail++; $display("FAIL lui: got %h expected 12340000", bus.ex_to_mem_bus[31:0]); end
    issue(mk(32'h108, {6'h0D, 5'd6, 5'd6, 16'h5678}, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd6, 1'b0, 32'h1234_0000, 32'd0));
    n_checks++; if (bus.ex_to_mem_bus[31:0] !== 32'h1234_5678) begin n_fail++; $display("FAIL ori: got %h expected 12345678", bus.ex_to_mem_bus[31:0]); end
    issue(mk(32'h10C, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2A}, 12'h200, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'hFFFF_FFFF, 32'd1));
    n_checks++; if (bus.ex_to_mem_bus[31:0] !== 32'd1) begin n_fail++; $display("FAIL slt: got %h expected 1", bus.ex_to_mem_bus[31:0]); end
    issue(mk(32'h110, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2B}, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'hFFFF_FFFF, 32'd1));
    n_checks++; if (bus.ex_to_mem_bus[31:0] !== 32'd0) begin n_fail++; $display("FAIL sltu: got %h expected 0", bus.ex_to_mem_bus[31:0]); end
    issue(mk(32'h114, {6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h03}, 12'h002, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd0, 32'h8000_0000));
    n_checks++; if (bus.ex_to_mem_bus[31:0] !== 32'hF800_0000) begin n_fail++; $display("FAIL sra: got %h expected f8000000", bus.ex_to_mem_bus[31:0]); end
  endtask

  task automatic test_alu_random();
    r_auto = 1'b0;
    r_stall = 6'd0;
    for (int i = 0; i < 40; i++) begin
      int k, c1, c2;
      logic [31:0] pc, inst, d1, d2, a, b, exp_res;
      logic [11:0] op;
      logic [2:0] s1;
      logic [3:0] s2, wen;
      logic en, we, sres;
      logic [4:0] wa;
      k  = int'($urandom_range(0, 12));
      c1 = int'($urandom_range(0, 3));
      c2 = int'($urandom_range(0, 4));
      pc = $urandom;
      inst = {6'($urandom_range(1, 63)), 26'($urandom)};
      d1 = $urandom;
      d2 = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      en = 1'($urandom); wen = 4'($urandom); we = 1'($urandom); sres = 1'($urandom); wa = 5'($urandom);
      op = 12'd0;
      if (k < 12) op[11 - k] = 1'b1;
      s1 = (c1 == 0) ? 3'b000 : 3'(1 << (c1 - 1));
      s2 = (c2 == 0) ? 4'b0000 : 4'(1 << (c2 - 1));
      case (c1)
        1: a = d1;
        2: a = pc;
        3: a = {27'd0, inst[10:6]};
        default: a = 32'd0;
      endcase
      case (c2)
        1: b = d2;
        2: b = {{16{inst[15]}}, inst[15:0]};
        3: b = 32'd8;
        4: b = {16'd0, inst[15:0]};
        default: b = 32'd0;
      endcase
      exp_res = ref_alu(k, a, b);
      issue(mk(pc, inst, op, s1, s2, en, wen, we, wa, sres, d1, d2));
      n_checks++; if (bus.ex_to_mem_bus !== {pc, en, wen, sres, we, wa, exp_res}) begin n_fail++; $display("FAIL rand_mem[%0d] k=%0d: got %h expected %h", i, k, bus.ex_to_mem_bus, {pc, en, wen, sres, we, wa, exp_res}); end
      n_checks++; if (bus.ex_to_id_bus !== {we & ~sres, wa, exp_res}) begin n_fail++; $display("FAIL rand_fwd[%0d]: got %h expected %h", i, bus.ex_to_id_bus, {we & ~sres, wa, exp_res}); end
      n_checks++; if (bus.data_sram_addr !== exp_res || bus.data_sram_wdata !== d2 || bus.data_sram_en !== en || bus.data_sram_wen !== wen)
        begin n_fail++; $display("FAIL rand_sram[%0d]: got addr=%h wdata=%h en=%b wen=%h expected addr=%h wdata=%h en=%b wen=%h", i, bus.data_sram_addr, bus.data_sram_wdata, bus.data_sram_en, bus.data_sram_wen, exp_res, d2, en, wen); end
      n_checks++; if (bus.ex_is_load !== (en & sres & (wen == 4'd0))) begin n_fail++; $display("FAIL rand_is_load[%0d]: got %b expected %b", i, bus.ex_is_load, en & sres & (wen == 4'd0)); end
    end
  endtask

  task automatic test_load_store();
    r_auto = 1'b0;
    r_stall = 6'd0;
    issue(mk(32'h200, {6'h23, 5'd1, 5'd7, 16'hFFFC}, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd7, 1'b1, 32'h0000_1000, 32'h1111_2222));
    n_checks++; if (bus.ex_is_load !== 1'b1) begin n_fail++; $display("FAIL load_is_load: got %b expected 1", bus.ex_is_load); end
    n_checks++; if (bus.ex_to_id_bus[37] !== 1'b0) begin n_fail++; $display("FAIL load_fwd_we: got %b expected 0", bus.ex_to_id_bus[37]); end
    n_checks++; if (bus.data_sram_en !== 1'b1 || bus.data_sram_addr !== 32'h0000_0FFC) begin n_fail++; $display("FAIL load_req: got en=%b addr=%h expected en=1 addr=00000ffc", bus.data_sram_en, bus.data_sram_addr); end
    issue(mk(32'h204, {6'h2B, 5'd1, 5'd7, 16'h0010}, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h0000_2000, 32'hDEAD_BEEF));
    n_checks++; if (bus.data_sram_wen !== 4'hF || bus.data_sram_wdata !== 32'hDEAD_BEEF || bus.data_sram_addr !== 32'h0000_2010 || bus.ex_is_load !== 1'b0)
      begin n_fail++; $display("FAIL store_req: got wen=%h wdata=%h addr=%h load=%b expected wen=f wdata=deadbeef addr=00002010 load=0", bus.data_sram_wen, bus.data_sram_wdata, bus.data_sram_addr, bus.ex_is_load); end
  endtask

  task automatic test_stall();
    logic [158:0] x;
    r_auto = 1'b0;
    r_stall = 6'd0;
    x = mk(32'h300, {6'h09, 5'd2, 5'd9, 16'h0010}, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 32'd5, 32'd0);
    issue(x);
    n_checks++; if (bus.ex_to_mem_bus !== {32'h300, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'd21}) begin n_fail++; $display("FAIL stall_pre: got %h expected %h", bus.ex_to_mem_bus, {32'h300, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'd21}); end
    @(negedge clk);
    r_stall = 6'b001100;
    issue(mk(32'h304, 32'h2000_0000, 12'h020, 3'b001, 4'b0001, 1'b1, 4'h3, 1'b1, 5'd1, 1'b0, 32'hFF, 32'hFF00));
    n_checks++; if (bus.ex_to_mem_bus !== {32'h300, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'd21}) begin n_fail++; $display("FAIL stall_hold: got %h expected %h", bus.ex_to_mem_bus, {32'h300, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'd21}); end
    @(negedge clk);
    r_stall = 6'b000100;
    @(posedge clk);
    #1;
    n_checks++; if (bus.ex_to_mem_bus !== 76'd0 || bus.ex_to_id_bus !== 38'd0) begin n_fail++; $display("FAIL stall_bubble: got mem=%h id=%h expected 0", bus.ex_to_mem_bus, bus.ex_to_id_bus); end
    @(negedge clk);
    r_stall = 6'd0;
    @(posedge clk);
    #1;
    n_checks++; if (bus.ex_to_mem_bus[31:0] !== 32'h0000_FFFF) begin n_fail++; $display("FAIL stall_release: got %h expected 0000ffff", bus.ex_to_mem_bus[31:0]); end
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    int exp_cyc, cyc;
    ref_div(sgn, a, b, eq, er);
    exp_cyc = (b == 32'd0) ? 1 : 33;
    r_auto = 1'b1;
    issue(mk(32'h500, {6'd0, 5'd4, 5'd5, 10'd0, sgn ? 6'h1A : 6'h1B}, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b));
    bus.id_to_ex_bus = mk_mf(1'b0, 5'd8);
    cyc = 0;
    while (bus.stallreq_for_ex === 1'b1 && cyc < 100) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    n_checks++; if (cyc != exp_cyc) begin n_fail++; $display("FAIL div_stall_cycles a=%h b=%h: got %0d expected %0d", a, b, cyc, exp_cyc); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.ex_to_id_bus !== {1'b1, 5'd8, eq}) begin n_fail++; $display("FAIL div_lo a=%h b=%h: got %h expected %h", a, b, bus.ex_to_id_bus, {1'b1, 5'd8, eq}); end
    n_checks++; if (bus.stallreq_for_ex !== 1'b0) begin n_fail++; $display("FAIL div_no_retrigger: got %b expected 0", bus.stallreq_for_ex); end
    issue(mk_mf(1'b1, 5'd9));
    n_checks++; if (bus.ex_to_id_bus !== {1'b1, 5'd9, er}) begin n_fail++; $display("FAIL div_hi a=%h b=%h: got %h expected %h", a, b, bus.ex_to_id_bus, {1'b1, 5'd9, er}); end
    m_hi = er;
    m_lo = eq;
  endtask

  task automatic test_div();
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    run_div(1'b0, 32'd100, 32'd0);
    run_div(1'b1, $urandom, 32'($urandom_range(1, 15)));
    run_div(1'b0, $urandom, $urandom);
    run_div(1'b1, $urandom, 32'hFFFF_FFFF - 32'($urandom_range(0, 200)));
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div(1'b1, 32'hFFFF_FF00, 32'd0);
  endtask

  task automatic test_div_reset();
    r_auto = 1'b1;
    issue(mk(32'h600, {6'd0, 5'd4, 5'd5, 10'd0, 6'h1A}, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd1000, 32'd3));
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (bus.stallreq_for_ex !== 1'b1) begin n_fail++; $display("FAIL rst_div_busy: got %b expected 1", bus.stallreq_for_ex); end
    @(negedge clk);
    rst = 1'b1;
    bus.id_to_ex_bus = '0;
    @(posedge clk);
    #1;
    n_checks++; if (bus.stallreq_for_ex !== 1'b0) begin n_fail++; $display("FAIL rst_div_stallreq: got %b expected 0", bus.stallreq_for_ex); end
    @(negedge clk);
    rst = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    issue(mk_mf(1'b1, 5'd10));
    n_checks++; if (bus.ex_to_id_bus !== {1'b1, 5'd10, m_hi}) begin n_fail++; $display("FAIL rst_div_hi: got %h expected %h", bus.ex_to_id_bus, {1'b1, 5'd10, m_hi}); end
    issue(mk_mf(1'b0, 5'd11));
    n_checks++; if (bus.ex_to_id_bus !== {1'b1, 5'd11, m_lo}) begin n_fail++; $display("FAIL rst_div_lo: got %h expected %h", bus.ex_to_id_bus, {1'b1, 5'd11, m_lo}); end
  endtask

  task automatic test_mult();
    logic [31:0] a, b;
    run_div(1'b0, 32'd1234567, 32'd1000);
    for (int i = 0; i < 2; i++) begin
      logic [63:0] p;
      a = (i == 0) ? 32'hFFFF_FFFD : $urandom;
      b = (i == 0) ? 32'd7 : $urandom;
      p = (i == 0) ? 64'($signed(64'(signed'(a))) * 64'(signed'(b))) : {32'd0, a} * {32'd0, b};
      r_auto = 1'b1;
      issue(mk(32'h700, {6'd0, 5'd4, 5'd5, 10'd0, (i == 0) ? 6'h18 : 6'h19}, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b));
      n_checks++; if (bus.stallreq_for_ex !== 1'b0) begin n_fail++; $display("FAIL mult_stallreq[%0d]: got %b expected 0", i, bus.stallreq_for_ex); end
`ifdef EX_MULT_EN
      m_hi = p[63:32];
      m_lo = p[31:0];
`endif
      issue(mk_mf(1'b1, 5'd12));
      n_checks++; if (bus.ex_to_id_bus !== {1'b1, 5'd12, m_hi}) begin n_fail++; $display("FAIL mult_hi[%0d] p=%h: got %h expected %h", i, p, bus.ex_to_id_bus, {1'b1, 5'd12, m_hi}); end
      issue(mk_mf(1'b0, 5'd13));
      n_checks++; if (bus.ex_to_id_bus !== {1'b1, 5'd13, m_lo}) begin n_fail++; $display("FAIL mult_lo[%0d] p=%h: got %h expected %h", i, p, bus.ex_to_id_bus, {1'b1, 5'd13, m_lo}); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_load_store();
    test_stall();
    test_div();
    test_div_reset();
    test_mult();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; the consumer of the ID stage's id_to_ex_bus.
- Registers the ID/EX bus under stall control and evaluates the one-hot ALU operation.
- Drives the data SRAM request, returns the forwarding bus to ID, and sends ex_to_mem_bus onward.
- Contains HI/LO and a multi-cycle radix-2 divider (div/divu, decoded from the carried inst). The divider raises stallreq while busy.

Parameters:
- ID_TO_EX_WD, 159, ID/EX bus width; layout {pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}.
- EX_TO_MEM_WD, 76, ex_to_mem_bus width; layout {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- EX_TO_ID_WD, 38, forwarding bus width; layout {we, waddr[4:0], wdata[31:0]}.
- STALL_W, 6, stall bus width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  STALL_W  pipeline stall vector; 1 = Stop.
- id_to_ex_bus  in  ID_TO_EX_WD  decoded instruction from ID.
- ex_to_mem_bus  out  EX_TO_MEM_WD  to MEM stage.
- ex_to_id_bus  out  EX_TO_ID_WD  forwarding to ID.
- ex_is_load  out  1  EX holds a load (load-use hazard indication for control).
- stallreq_for_ex  out  1  divider busy.
- data_sram_en  out  1  data SRAM enable.
- data_sram_wen  out  4  byte write enables.
- data_sram_addr  out  32  data SRAM address.
- data_sram_wdata  out  32  store data.

Behaviour:
- ID/EX register:
  - rst clears it to 0.
  - If stall[2]=Stop and stall[3]=NoStop, load 0 (bubble).
  - Else if stall[2]=NoStop, load id_to_ex_bus.
  - Else hold.
- Source 1 mux (one-hot): [0] rdata1; [1] pc; [2] {27'b0, inst[10:6]}.
- Source 2 mux (one-hot): [0] rdata2; [1] sign-extended inst[15:0]; [2] 32'd8; [3] zero-extended inst[15:0].
- All-zero select yields 0 for that source.
- alu_op bit order is 11..0 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - add/sub are 32-bit wrapping, no overflow trap.
  - slt is signed and sltu is unsigned; the result is 32'd1 or 32'd0.
  - sll/srl/sra shift src2 by src1[4:0].
  - lui gives {src2[15:0], 16'b0}.
  - All-zero alu_op gives 0.
- Store/load path:
  - data_sram_en = data_ram_en.
  - data_sram_wen = data_ram_wen.
  - data_sram_addr = ALU result.
  - data_sram_wdata = rdata2.
  - All four are combinational from the ID/EX register.
- Forwarding bus:
  - ex_to_id_bus.we = rf_we & ~sel_rf_res.
  - waddr = rf_waddr.
  - wdata = ex_result.
- ex_is_load = data_ram_en & sel_rf_res & (data_ram_wen==0).
- Decode from inst (opcode 0):
  - div: func 0x1A.
  - divu: func 0x1B.
  - mfhi: func 0x10.
  - mflo: func 0x12.
- mfhi/mflo: ex_result = HI/LO; rf_we forced to 1 and rf_waddr forced to inst[15:11].
- HI and LO reset to 0.
- Divider FSM has states IDLE, BUSY, DONE.
- IDLE:
  - div/divu present and rdata2 != 0: latch |rs| and |rt| (signed, or raw for divu) and record the result signs; counter = 0; go to BUSY. stallreq = 1.
  - rdata2 == 0: go directly to DONE with quotient 0xFFFFFFFF and remainder = rdata1. stallreq = 1.
- BUSY:
  - One restoring shift-subtract step per cycle; counter increments.
  - After the 32nd step go to DONE. stallreq = 1.
- DONE:
  - stallreq = 0.
  - Sign-correct the results: quotient negated if the signs differ; remainder takes the dividend's sign.
  - LO = quotient and HI = remainder, written at this edge; go to IDLE.
- Latency for a nonzero divisor: 34 cycles in EX (1 IDLE + 32 BUSY + 1 DONE).
- A division instruction advances at the DONE edge. It must not re-trigger, because the FSM returns to IDLE as the register loads the next instruction.
- A bubble (all-zero bus) never starts the divider.
- rst mid-division: FSM returns to IDLE, HI/LO clear to 0, stallreq deasserts the next cycle.

Optional Feature:
- Macro: EX_MULT_EN.
- Defined: mult (func 0x18, signed) and multu (func 0x19) are decoded.
  - The 64-bit product is computed combinationally.
  - {HI, LO} are written at the edge where EX advances (stall[2]=NoStop).
  - No stallreq is raised.
- Undefined: mult/multu behave as nops in EX; HI/LO are unchanged.

Test Plan:
- addiu (add, src1 rs=0x7FFFFFFF, src2 imm 0x0001) -> ex_result 0x80000000; ex_to_id_bus {1, rt, 0x80000000}.
- lui imm 0x1234 then ori rs=0x12340000 imm 0x5678 -> results 0x12340000, then 0x12345678.
- slt -1 vs 1 -> 1; sltu -1 vs 1 -> 0; sra 0x80000000 by sa=4 -> 0xF8000000.
- div -7 / 2 -> stallreq high for exactly 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; a following mflo writes 0xFFFFFFFD to rd.
- divu 100 / 0 -> stallreq for 1 cycle; LO=0xFFFFFFFF, HI=100. Second case: rst asserted at BUSY cycle 10 -> HI=LO=0, stallreq=0.
- Stall test: stall[2]=Stop with stall[3]=NoStop -> next ex_to_mem_bus all zero. Load (en=1, wen=0, sel_rf_res=1) -> ex_is_load=1 and ex_to_id_bus.we=0.
